// File: rtl/seven_seg_pkg.sv
// Shared 7-segment encoding (active-low, gfedcba) and reader types.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

endpackage

// File: rtl/seven_seg_reader_dec.sv
// Combinational decode of one active-low segment pattern back to a hex nibble.
module seg_to_nibble
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output seg_dec_t   o_dec_c
);

    always_comb begin
        o_dec_c = '{legal: 1'b1, blank: 1'b0, nibble: 4'h0};
        case (i_seg)
            SEG_0:     o_dec_c.nibble = 4'h0;
            SEG_1:     o_dec_c.nibble = 4'h1;
            SEG_2:     o_dec_c.nibble = 4'h2;
            SEG_3:     o_dec_c.nibble = 4'h3;
            SEG_4:     o_dec_c.nibble = 4'h4;
            SEG_5:     o_dec_c.nibble = 4'h5;
            SEG_6:     o_dec_c.nibble = 4'h6;
            SEG_7:     o_dec_c.nibble = 4'h7;
            SEG_8:     o_dec_c.nibble = 4'h8;
            SEG_9:     o_dec_c.nibble = 4'h9;
            SEG_A:     o_dec_c.nibble = 4'hA;
            SEG_B:     o_dec_c.nibble = 4'hB;
            SEG_C:     o_dec_c.nibble = 4'hC;
            SEG_D:     o_dec_c.nibble = 4'hD;
            SEG_E:     o_dec_c.nibble = 4'hE;
            SEG_F:     o_dec_c.nibble = 4'hF;
            SEG_BLANK: begin
                o_dec_c.legal = 1'b0;
                o_dec_c.blank = 1'b1;
            end
            default:   o_dec_c.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Samples a multiplexed active-low 7-segment bus, debounces each digit pattern,
// assembles one nibble per digit into a word and offers it on valid/ready.
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    seg_valid,
    output logic [4*NUM_DIGITS-1:0] word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    err_illegal,
    output logic                    err_sel,
    output logic                    err_ovr,
    input  logic                    err_clr
);

    localparam int unsigned WORD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_e                r_state;
    logic [CNT_W-1:0]      r_run;
    logic [NUM_DIGITS-1:0] r_prev_sel;
    logic [6:0]            r_prev_seg;
    logic [WORD_W-1:0]     r_slots;
    logic [NUM_DIGITS-1:0] r_mask;

    seg_dec_t              w_dec;
    logic                  w_onehot;
    logic                  w_qual;
    logic                  w_sel_err;
    logic                  w_same;
    logic                  w_accept;
    logic                  w_take;
    logic                  w_bad_pat;
    logic [CNT_W-1:0]      w_run_next;
    logic [WORD_W-1:0]     w_slots_next;
    logic [NUM_DIGITS-1:0] w_mask_next;
    logic                  w_done;
    logic                  w_ovr;

    seg_to_nibble u_dec (
        .i_seg   (seg_in),
        .o_dec_c (w_dec)
    );

    // Run tracking: a pattern is accepted exactly once, when its run length hits STABLE_CYCLES.
    always_comb begin
        w_onehot  = (dig_sel != '0) && ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
        w_qual    = seg_valid & w_onehot;
        w_sel_err = seg_valid & ~w_onehot;
        w_same    = (r_run != '0) && (dig_sel == r_prev_sel) && (seg_in == r_prev_seg);
        w_run_next = '0;
        if (w_qual) begin
            if (!w_same)
                w_run_next = CNT_W'(1);
            else if (r_run == CNT_MAX)
                w_run_next = r_run;
            else
                w_run_next = r_run + CNT_W'(1);
        end
        w_accept  = w_qual & (w_same ? (r_run == CNT_LAST) : (STABLE_CYCLES == 1));
        w_take    = w_accept & w_dec.legal;
        w_bad_pat = w_accept & ~w_dec.legal & ~w_dec.blank;
    end

    // Slot/mask update; dig_sel is one-hot whenever w_take is set.
    always_comb begin
        w_slots_next = r_slots;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_take && dig_sel[k])
                w_slots_next[4*k +: 4] = w_dec.nibble;
        end
        w_mask_next = r_mask | (w_take ? dig_sel : '0);
        w_done      = &w_mask_next;
        w_ovr       = w_done & (r_state == HOLD) & ~word_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= COLLECT;
            r_run       <= '0;
            r_prev_sel  <= '0;
            r_prev_seg  <= '0;
            r_slots     <= '0;
            r_mask      <= '0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            err_illegal <= 1'b0;
            err_sel     <= 1'b0;
            err_ovr     <= 1'b0;
        end else begin
            r_run   <= w_run_next;
            r_slots <= w_slots_next;
            r_mask  <= w_done ? '0 : w_mask_next;
            if (w_qual) begin
                r_prev_sel <= dig_sel;
                r_prev_seg <= seg_in;
            end
            // A new error in the same cycle as err_clr leaves the bit set.
            err_illegal <= w_bad_pat | (err_illegal & ~err_clr);
            err_sel     <= w_sel_err | (err_sel & ~err_clr);
            err_ovr     <= w_ovr     | (err_ovr & ~err_clr);
            case (r_state)
                COLLECT: begin
                    if (w_done) begin
                        word_out   <= w_slots_next;
                        word_valid <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (word_ready) begin
                        if (w_done) begin
                            word_out <= w_slots_next;
                        end else begin
                            word_valid <= 1'b0;
                            r_state    <= COLLECT;
                        end
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed and randomized checks of seven_seg_reader against a behavioural model.
module tb_seven_seg_reader;

    localparam int STABLE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        seg_valid;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        err_illegal;
    logic        err_sel;
    logic        err_ovr;
    logic        err_clr;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state
    int          m_run;
    logic [3:0]  m_prev_sel;
    logic [6:0]  m_prev_seg;
    logic [3:0]  m_slot [4];
    logic [3:0]  m_mask;
    logic [15:0] m_word;
    logic        m_valid, m_ei, m_es, m_eo;

    seven_seg_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .seg_valid   (seg_valid),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .err_illegal (err_illegal),
        .err_sel     (err_sel),
        .err_ovr     (err_ovr),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: advances one clock using the current inputs.
    task automatic model_step();
        bit ei_n, es_n, eo_n;
        int k, lk;
        ei_n = 0; es_n = 0; eo_n = 0;
        if (reset) begin
            m_run = 0; m_prev_sel = '0; m_prev_seg = '0; m_mask = '0;
            for (int i = 0; i < 4; i++) m_slot[i] = '0;
            m_word = '0; m_valid = 0; m_ei = 0; m_es = 0; m_eo = 0;
        end else begin
            if (seg_valid && $countones(dig_sel) != 1) begin
                es_n = 1; m_run = 0;
            end else if (!seg_valid) begin
                m_run = 0;
            end else begin
                if (m_run > 0 && dig_sel == m_prev_sel && seg_in == m_prev_seg) m_run++;
                else m_run = 1;
                m_prev_sel = dig_sel;
                m_prev_seg = seg_in;
                if (m_run == STABLE) begin
                    k = 0;
                    for (int i = 0; i < 4; i++) if (dig_sel[i]) k = i;
                    lk = -1;
                    for (int v = 0; v < 16; v++) if (seg_tab[v] == seg_in) lk = v;
                    if (lk >= 0) begin
                        m_slot[k] = 4'(lk);
                        m_mask[k] = 1'b1;
                    end else if (seg_in != 7'h7F) begin
                        ei_n = 1;
                    end
                end
            end
            if (m_mask == 4'hF) begin
                m_mask = '0;
                if (!m_valid || word_ready) begin
                    m_word  = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
                    m_valid = 1;
                end else begin
                    eo_n = 1;
                end
            end else if (m_valid && word_ready) begin
                m_valid = 0;
            end
            m_ei = ei_n | (m_ei & !err_clr);
            m_es = es_n | (m_es & !err_clr);
            m_eo = eo_n | (m_eo & !err_clr);
        end
    endtask

    task automatic cyc(input logic [3:0] sel, input logic [6:0] seg, input logic sv,
                       input logic rdy, input logic clr, input logic rst);
        dig_sel = sel; seg_in = seg; seg_valid = sv;
        word_ready = rdy; err_clr = clr; reset = rst;
        model_step();
        @(posedge clk);
        #1;
        check("word", word_out, m_word);
        check("valid", word_valid, m_valid);
        check("err_illegal", err_illegal, m_ei);
        check("err_sel", err_sel, m_es);
        check("err_ovr", err_ovr, m_eo);
    endtask

    task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(sel, seg, 1'b1, rdy, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [6:0] seg, input logic rdy);
        for (int d = 0; d < 4; d++) hold(4'(1 << d), seg, 2, rdy);
    endtask

    initial begin
        int n, d, r;
        logic [3:0] sel;
        logic [6:0] seg;
        logic sv, rdy, clr, rst;

        cyc('0, '0, 0, 0, 0, 1);
        cyc('0, '0, 0, 0, 0, 1);
        check("rst_word", word_out, 32'h0);
        check("rst_valid", word_valid, 32'h0);

        // 1: basic frame 0123 with ready held high
        hold(4'b0001, 7'h30, 2, 1);
        hold(4'b0010, 7'h24, 2, 1);
        hold(4'b0100, 7'h79, 2, 1);
        hold(4'b1000, 7'h40, 1, 1);
        check("t1_pre_valid", word_valid, 32'h0);
        hold(4'b1000, 7'h40, 1, 1);
        check("t1_word", word_out, 32'h0123);
        check("t1_valid", word_valid, 32'h1);
        cyc('0, '0, 0, 1, 0, 0);
        check("t1_valid_drop", word_valid, 32'h0);

        // 2: single-cycle 8 is not accepted; stable F is
        hold(4'b0010, 7'h00, 1, 1);
        hold(4'b0010, 7'h0E, 2, 1);
        hold(4'b0001, 7'h40, 2, 1);
        hold(4'b0100, 7'h40, 2, 1);
        hold(4'b1000, 7'h40, 2, 1);
        check("t2_word", word_out, 32'h00F0);
        check("t2_err", err_illegal, 32'h0);
        cyc('0, '0, 0, 1, 0, 0);

        // 3: illegal pattern, then clear
        hold(4'b0100, 7'h7E, 2, 1);
        check("t3_err", err_illegal, 32'h1);
        check("t3_valid", word_valid, 32'h0);
        cyc('0, '0, 0, 1, 1, 0);
        check("t3_clr", err_illegal, 32'h0);

        // 4: bad select and blank
        cyc(4'b0011, 7'h40, 1, 1, 0, 0);
        check("t4_sel", err_sel, 32'h1);
        hold(4'b0001, 7'h7F, 5, 1);
        check("t4_blank_ill", err_illegal, 32'h0);
        check("t4_blank_valid", word_valid, 32'h0);
        cyc('0, '0, 0, 1, 1, 0);

        // 5: overrun with ready low
        frame(7'h08, 0);
        check("t5_word_a", word_out, 32'hAAAA);
        check("t5_valid_a", word_valid, 32'h1);
        frame(7'h12, 0);
        check("t5_word_keep", word_out, 32'hAAAA);
        check("t5_ovr", err_ovr, 32'h1);
        cyc('0, '0, 0, 1, 0, 0);
        check("t5_drop", word_valid, 32'h0);
        cyc('0, '0, 0, 1, 1, 0);

        // 6: reset mid-frame discards partial slots
        hold(4'b0001, 7'h79, 2, 1);
        hold(4'b0010, 7'h79, 2, 1);
        hold(4'b0100, 7'h79, 2, 1);
        cyc('0, '0, 0, 1, 0, 1);
        hold(4'b1000, 7'h79, 2, 1);
        for (int i = 0; i < 3; i++) begin
            cyc('0, '0, 0, 1, 0, 0);
            check("t6_valid", word_valid, 32'h0);
        end

        // Randomized bursts
        for (int b = 0; b < 700; b++) begin
            d = $urandom_range(0, 3);
            sel = 4'(1 << d);
            if ($urandom_range(0, 19) == 0) sel = 4'($urandom);
            r = $urandom_range(0, 9);
            if (r < 8)       seg = seg_tab[$urandom_range(0, 15)];
            else if (r == 8) seg = 7'h7F;
            else             seg = 7'($urandom);
            sv  = ($urandom_range(0, 9) != 0);
            n   = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                rdy = 1'($urandom);
                clr = ($urandom_range(0, 29) == 0);
                rst = ($urandom_range(0, 149) == 0);
                cyc(sel, seg, sv, rdy, clr, rst);
            end
            if ($urandom_range(0, 5) == 0)
                cyc('0, '0, 0, 1'($urandom), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
